// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the banked line memory.
// Geometry helpers turn the top-level parameters into line and address field widths.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int line_bytes(input int blockWidth);
    return blockWidth / 8;
  endfunction

  function automatic int off_bits(input int blockWidth);
    return $clog2(blockWidth / 8);
  endfunction

  function automatic int mem_bytes_bits(input int memSize, input int dataWidth);
    return $clog2(memSize * dataWidth / 8);
  endfunction

  function automatic int cnt_w(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_line_array.sv
// Single-port, line-wide synchronous storage with byte-strobed writes.
// The contents have no reset, so there is no depth-long clearing sequence.
module mem_line_array #(
  parameter int DEPTH = 16384,
  parameter int IDX_W = 14,
  parameter int WIDTH = 128
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [IDX_W-1:0]   idx,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // The read register is only loaded by reads, so it holds its value across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WIDTH / 8; b++) begin
          if (wstrb[b]) begin
            r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= r_mem[idx];
      end
    end
  end

endmodule

// File: rtl/banked_line_memory.sv
// Line-granular main-memory model with valid/ready request and response channels.
// Each request is served after a fixed latency; out-of-range addresses get an error response.
module banked_line_memory
  import mem_pkg::*;
#(
  parameter int MEM_SIZE    = 65536,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 128,
  parameter int LATENCY     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [BLOCK_WIDTH-1:0]   req_wdata,
  input  logic [BLOCK_WIDTH/8-1:0] req_wstrb,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [BLOCK_WIDTH-1:0]   resp_rdata,
  output logic                     resp_write,
  output logic                     resp_err
);

  localparam int LINE_BYTES     = line_bytes(BLOCK_WIDTH);
  localparam int OFF_BITS       = off_bits(BLOCK_WIDTH);
  localparam int MEM_BYTES_BITS = mem_bytes_bits(MEM_SIZE, DATA_WIDTH);
  localparam int CNT_W          = cnt_w(LATENCY);
  localparam int IDX_W          = MEM_BYTES_BITS - OFF_BITS;
  localparam int DEPTH          = MEM_SIZE * DATA_WIDTH / BLOCK_WIDTH;

  if (LATENCY < 1) begin : g_badLatency
    $error("banked_line_memory: LATENCY must be >= 1");
  end
  if ((MEM_SIZE % (BLOCK_WIDTH / DATA_WIDTH)) != 0) begin : g_badSize
    $error("banked_line_memory: MEM_SIZE must be a multiple of BLOCK_WIDTH/DATA_WIDTH");
  end
  if (LINE_BYTES * 8 != BLOCK_WIDTH) begin : g_badBlock
    $error("banked_line_memory: BLOCK_WIDTH must be a whole number of bytes");
  end

  state_t r_state;
  state_t w_stateNext;
  logic [CNT_W-1:0]         r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_write;
  logic                     r_addrErr;
  logic [BLOCK_WIDTH-1:0]   r_wdata;
  logic [BLOCK_WIDTH/8-1:0] r_wstrb;
  logic                     r_respWrite;
  logic                     r_respErr;
  logic                     r_respRead;
  logic                     w_accept;
  logic                     w_access;
  logic                     w_arrEn;
  logic                     w_rangeErr;
  logic [BLOCK_WIDTH-1:0]   w_arrRdata;
  logic                     w_unused;

  // Any address bit above the implemented byte range marks the request as an error.
  if (ADDR_WIDTH > MEM_BYTES_BITS) begin : g_range
    assign w_rangeErr = |req_addr[ADDR_WIDTH-1:MEM_BYTES_BITS];
  end else begin : g_noRange
    assign w_rangeErr = 1'b0;
  end

  assign w_unused = ^req_addr[OFF_BITS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_cnt <= CNT_W'(LATENCY - 1);
      end else if (r_state == BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_stateNext = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_access    = 1'b1;
          w_stateNext = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx     <= req_addr[MEM_BYTES_BITS-1:OFF_BITS];
      r_write   <= req_write;
      r_wdata   <= req_wdata;
      r_wstrb   <= req_wstrb;
      r_addrErr <= w_rangeErr;
    end
  end

  // Reset on the access edge must drop the request, so the array is gated by rst too.
  assign w_arrEn = w_access && !rst && !r_addrErr;

  mem_line_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W),
    .WIDTH(BLOCK_WIDTH)
  ) u_array (
    .clk  (clk),
    .en   (w_arrEn),
    .we   (r_write),
    .idx  (r_idx),
    .wdata(r_wdata),
    .wstrb(r_wstrb),
    .rdata(w_arrRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_respWrite <= 1'b0;
      r_respErr   <= 1'b0;
      r_respRead  <= 1'b0;
    end else if (w_access) begin
      r_respWrite <= r_write;
      r_respErr   <= r_addrErr;
      r_respRead  <= !r_write && !r_addrErr;
    end else if (r_state == RESP && resp_ready) begin
      r_respWrite <= 1'b0;
      r_respErr   <= 1'b0;
      r_respRead  <= 1'b0;
    end
  end

  // Write and error responses carry zero data; reads expose the array register.
  assign resp_rdata = r_respRead ? w_arrRdata : '0;
  assign resp_write = r_respWrite;
  assign resp_err   = r_respErr;

endmodule

// File: tb/tb_banked_line_memory.sv
// Bench for banked_line_memory: vector table plus hand sequences, with a response scoreboard.
// Runs a LATENCY=3 instance and a LATENCY=7 instance side by side.
module tb_banked_line_memory;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         reqValid3, reqValid7, reqWrite, respReady;
  logic [31:0]  reqAddr;
  logic [127:0] reqWdata;
  logic [15:0]  reqWstrb;

  logic         reqReady3, respValid3, respWrite3, respErr3;
  logic [127:0] respRdata3;
  logic         reqReady7, respValid7, respWrite7, respErr7;
  logic [127:0] respRdata7;

  int sel = 3;
  logic         curReqReady, curRespValid, curRespWrite, curRespErr;
  logic [127:0] curRespRdata;

  assign curReqReady  = (sel == 7) ? reqReady7  : reqReady3;
  assign curRespValid = (sel == 7) ? respValid7 : respValid3;
  assign curRespWrite = (sel == 7) ? respWrite7 : respWrite3;
  assign curRespErr   = (sel == 7) ? respErr7   : respErr3;
  assign curRespRdata = (sel == 7) ? respRdata7 : respRdata3;

  banked_line_memory u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid3), .req_ready(reqReady3), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_wstrb(reqWstrb),
    .resp_valid(respValid3), .resp_ready(respReady), .resp_rdata(respRdata3),
    .resp_write(respWrite3), .resp_err(respErr3)
  );

  banked_line_memory #(.LATENCY(7)) u_dut7 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid7), .req_ready(reqReady7), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_wstrb(reqWstrb),
    .resp_valid(respValid7), .resp_ready(respReady), .resp_rdata(respRdata7),
    .resp_write(respWrite7), .resp_err(respErr7)
  );

  typedef struct {
    logic [127:0] rdata;
    logic         err;
    logic         write;
    int           lat;
  } exp_t;

  typedef struct {
    logic         write;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic [127:0] expRdata;
    logic         expErr;
    int           hold;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[15];
  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request/response transaction on the selected instance, holding resp_ready low for hold cycles.
  task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [127:0] wdata,
                               input logic [15:0] wstrb, input logic [127:0] expRdata,
                               input logic expErr, input int hold, input string name);
    exp_t e;
    int   n;
    e.rdata = expRdata;
    e.err   = expErr;
    e.write = write;
    e.lat   = sel;
    sbQ.push_back(e);
    @(negedge clk);
    if (sel == 7) reqValid7 = 1'b1; else reqValid3 = 1'b1;
    reqWrite = write;
    reqAddr  = addr;
    reqWdata = wdata;
    reqWstrb = wstrb;
    checkOutput({name, " req_ready idle"}, curReqReady, 1);
    @(posedge clk);
    #1;
    reqValid3 = 1'b0;
    reqValid7 = 1'b0;
    reqWrite  = ~write;
    reqAddr   = ~addr;
    reqWdata  = ~wdata;
    reqWstrb  = ~wstrb;
    n = 0;
    while (!curRespValid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sbQ.pop_front();
    if (!curRespValid) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s timeout: resp_valid still 0 after %0d cycles, expected after %0d", name, n, e.lat);
      return;
    end
    checkOutput({name, " latency"}, n, e.lat);
    checkOutput({name, " rdata"}, curRespRdata, e.rdata);
    checkOutput({name, " err"}, curRespErr, e.err);
    checkOutput({name, " write echo"}, curRespWrite, e.write);
    checkOutput({name, " req_ready in RESP"}, curReqReady, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput({name, " held valid"}, curRespValid, 1);
      checkOutput({name, " held rdata"}, curRespRdata, e.rdata);
      checkOutput({name, " held req_ready"}, curReqReady, 0);
    end
    respReady = 1'b1;
    #1;
    checkOutput({name, " req_ready with resp_ready"}, curReqReady, 0);
    @(posedge clk);
    #1;
    respReady = 1'b0;
    checkOutput({name, " valid after handshake"}, curRespValid, 0);
    checkOutput({name, " ready after handshake"}, curReqReady, 1);
  endtask

  initial begin
    rst       = 1'b1;
    reqValid3 = 1'b0;
    reqValid7 = 1'b0;
    reqWrite  = 1'b0;
    reqAddr   = '0;
    reqWdata  = '0;
    reqWstrb  = '0;
    respReady = 1'b0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 128'h88887777_66665555_44443333_22221111, 16'hFFFF, 128'h0, 1'b0, 0};
    vecs[1]  = '{1'b0, 32'h0000_0014, 128'h0, 16'h0, 128'h88887777_66665555_44443333_22221111, 1'b0, 0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 128'h11111111_11111111_11111111_11111111, 16'hFFFF, 128'h0, 1'b0, 0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 128'hCAFECAFE_DEADBEEF_CAFECAFE_CAFECAFE, 16'h0F00, 128'h0, 1'b0, 0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 128'h0, 16'h0, 128'h11111111_DEADBEEF_11111111_11111111, 1'b0, 5};
    vecs[5]  = '{1'b1, 32'h0000_0000, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'hFFFF, 128'h0, 1'b0, 0};
    vecs[6]  = '{1'b0, 32'h0004_0000, 128'h0, 16'h0, 128'h0, 1'b1, 0};
    vecs[7]  = '{1'b1, 32'h0004_0000, 128'h55555555_55555555_55555555_55555555, 16'hFFFF, 128'h0, 1'b1, 0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 128'h0, 16'h0, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 1'b0, 0};
    vecs[9]  = '{1'b1, 32'h0000_0030, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, 16'hFFFF, 128'h0, 1'b0, 0};
    vecs[10] = '{1'b1, 32'h0000_0030, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 16'h0000, 128'h0, 1'b0, 0};
    vecs[11] = '{1'b0, 32'h0000_003C, 128'h0, 16'h0, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, 1'b0, 0};
    vecs[12] = '{1'b1, 32'h0000_0030, 128'hAB000000_00000000_00000000_00000000, 16'h8000, 128'h0, 1'b0, 0};
    vecs[13] = '{1'b0, 32'h0000_0030, 128'h0, 16'h0, 128'hAB345678_9ABCDEF0_0F1E2D3C_4B5A6978, 1'b0, 0};
    vecs[14] = '{1'b0, 32'h8000_0010, 128'h0, 16'h0, 128'h0, 1'b1, 0};

    repeat (3) @(posedge clk);
    #1;
    for (int s = 3; s <= 7; s += 4) begin
      sel = s;
      #1;
      checkOutput("reset req_ready", curReqReady, 1);
      checkOutput("reset resp_valid", curRespValid, 0);
      checkOutput("reset resp_rdata", curRespRdata, 0);
      checkOutput("reset resp_write", curRespWrite, 0);
      checkOutput("reset resp_err", curRespErr, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 3;

    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].write, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb,
                    vecs[v].expRdata, vecs[v].expErr, vecs[v].hold, $sformatf("vec%0d", v));
    end

    // Reset lands on the edge where the in-flight write would be performed.
    @(negedge clk);
    reqValid3 = 1'b1;
    reqWrite  = 1'b1;
    reqAddr   = 32'h0000_0030;
    reqWdata  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    reqWstrb  = 16'hFFFF;
    @(posedge clk);
    #1;
    reqValid3 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busy reset req_ready", curReqReady, 1);
    checkOutput("busy reset resp_valid", curRespValid, 0);
    checkOutput("busy reset resp_rdata", curRespRdata, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0000_0030, 128'h0, 16'h0,
                  128'hAB345678_9ABCDEF0_0F1E2D3C_4B5A6978, 1'b0, 0, "read after busy reset");

    sel = 7;
    applyStimulus(1'b1, 32'h0000_0050, 128'h0BADF00D_13579BDF_2468ACE0_76543210, 16'hFFFF,
                  128'h0, 1'b0, 0, "lat7 write");
    applyStimulus(1'b0, 32'h0000_0058, 128'h0, 16'h0,
                  128'h0BADF00D_13579BDF_2468ACE0_76543210, 1'b0, 2, "lat7 read");
    applyStimulus(1'b0, 32'h0004_0050, 128'h0, 16'h0, 128'h0, 1'b1, 0, "lat7 error");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
